// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver (8E1 when UART_PARITY_EN is defined) with an
//            internal x OS_RATE oversample tick and a valid/ready byte output.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int OS_RATE   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err
);

    localparam int c_OS_DIV = CLK_FREQ / (BAUD_RATE * OS_RATE);
    localparam int c_DIV_W  = $clog2(c_OS_DIV);
    localparam int c_TICK_W = $clog2(OS_RATE);
    localparam logic [c_DIV_W-1:0]  c_OS_LAST   = c_DIV_W'(c_OS_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_HALF_LAST = c_TICK_W'(OS_RATE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_BIT_LAST  = c_TICK_W'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_rx_prev;
    logic [c_DIV_W-1:0]    r_os_cnt;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shreg;
    logic [7:0]            r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  w_tick;
`ifdef UART_PARITY_EN
    logic                  r_par_bad;
    logic                  r_parity_err;
`endif

    assign w_tick = (r_os_cnt == c_OS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_os_cnt  <= '0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
            r_os_cnt  <= w_tick ? '0 : r_os_cnt + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_HALF_LAST) begin
                            // A start bit that is high again at mid-bit was a glitch
                            r_tick_cnt <= '0;
                            r_bit_idx  <= '0;
                            r_state    <= r_rx_s ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_BIT_LAST) begin
                            r_tick_cnt <= '0;
                            r_shreg    <= {r_rx_s, r_shreg[7:1]};
                            r_bit_idx  <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_BIT_LAST) begin
                            r_tick_cnt <= '0;
                            r_par_bad  <= r_rx_s ^ (^r_shreg);
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_BIT_LAST) begin
                            r_tick_cnt <= '0;
                            if (r_rx_s) begin
                                if (!r_rx_valid || i_rx_ready) begin
                                    r_rx_data  <= r_shreg;
                                    r_rx_valid <= 1'b1;
`ifdef UART_PARITY_EN
                                    r_parity_err <= r_par_bad;
`endif
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                                r_state <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
`ifdef UART_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Table-driven and directed self-checking bench for uart_rx.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       i_rx;
    logic       i_rx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_parity_err;

    uart_rx #(
        .CLK_FREQ  (1600000),
        .BAUD_RATE (10000),
        .OS_RATE   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (i_rx),
        .i_rx_ready   (i_rx_ready),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cumulative event counters, sampled on the falling edge
    int         n_vrise = 0, n_vcyc = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_pv = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (o_rx_valid && !prev_valid) begin
            n_vrise++;
            last_data = o_rx_data;
            if (o_parity_err) n_pv++;
        end
        if (o_rx_valid)   n_vcyc++;
        if (o_frame_err)  n_fe++;
        if (o_overrun)    n_ov++;
        if (o_parity_err) n_pe++;
        prev_valid = o_rx_valid;
    end

    int errors = 0;
    int checks = 0;
    int s_vrise, s_vcyc, s_fe, s_ov, s_pe, s_pv;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        s_vrise = n_vrise; s_vcyc = n_vcyc; s_fe = n_fe;
        s_ov = n_ov; s_pe = n_pe; s_pv = n_pv;
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        repeat (c_BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
        i_rx = 1'b1;
    endtask

`ifdef UART_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[5] = '{8'h5A, 1'b1, 1, 8'h5A, 0};

        rst_n = 1'b0;
        i_rx = 1'b1;
        i_rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check("reset rx_valid",   int'(o_rx_valid),   0);
        check("reset rx_data",    int'(o_rx_data),    0);
        check("reset frame_err",  int'(o_frame_err),  0);
        check("reset overrun",    int'(o_overrun),    0);
        check("reset parity_err", int'(o_parity_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop);
            idle(30);
            check($sformatf("vec%0d valid_rises", v), n_vrise - s_vrise, vecs[v].exp_valid);
            check($sformatf("vec%0d valid_cycles", v), n_vcyc - s_vcyc, vecs[v].exp_valid);
            check($sformatf("vec%0d frame_err", v), n_fe - s_fe, vecs[v].exp_fe);
            check($sformatf("vec%0d overrun", v), n_ov - s_ov, 0);
            check($sformatf("vec%0d parity_err", v), n_pe - s_pe, 0);
            if (vecs[v].exp_valid != 0)
                check($sformatf("vec%0d rx_data", v), int'(last_data), int'(vecs[v].exp_data));
        end

        // Short low pulse must be rejected as a glitch
        snap();
        @(negedge clk);
        i_rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(200);
        check("glitch valid_rises", n_vrise - s_vrise, 0);
        check("glitch frame_err",   n_fe - s_fe, 0);
        check("glitch overrun",     n_ov - s_ov, 0);
        snap();
        send_frame(8'hC3, 1'b1);
        idle(30);
        check("post-glitch valid_rises", n_vrise - s_vrise, 1);
        check("post-glitch rx_data", int'(last_data), 8'hC3);

        // Back-to-back frames with the consumer stalled
        i_rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(30);
        check("overrun valid_rises", n_vrise - s_vrise, 1);
        check("overrun rx_data",     int'(o_rx_data), 8'h11);
        check("overrun pulses",      n_ov - s_ov, 1);
        check("overrun frame_err",   n_fe - s_fe, 0);
        check("overrun valid held",  int'(o_rx_valid), 1);
        @(negedge clk);
        i_rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake valid drop", int'(o_rx_valid), 0);
        idle(10);

`ifdef UART_PARITY_EN
        snap();
        send_frame_par(8'h07, 1'b0);
        idle(30);
        check("parity rx_data",       int'(last_data), 8'h07);
        check("parity valid_rises",   n_vrise - s_vrise, 1);
        check("parity_err pulses",    n_pe - s_pe, 1);
        check("parity_err with valid", n_pv - s_pv, 1);
`endif

        // Reset in the middle of data bit 4 while a byte is still pending
        i_rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        idle(30);
        check("pre-reset rx_data", int'(o_rx_data), 8'h33);
        @(negedge clk);
        i_rx = 1'b0;
        repeat (c_BIT_CLKS) @(negedge clk);
        i_rx = 1'b1;
        repeat (4 * c_BIT_CLKS + 80) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midframe reset rx_valid", int'(o_rx_valid), 0);
        check("midframe reset rx_data",  int'(o_rx_data),  0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        i_rx_ready = 1'b1;
        idle(50);
        snap();
        send_frame(8'h5A, 1'b1);
        idle(30);
        check("post-reset valid_rises", n_vrise - s_vrise, 1);
        check("post-reset rx_data",     int'(last_data), 8'h5A);
        check("post-reset frame_err",   n_fe - s_fe, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
